// File: rtl/muldiv_if.sv
// muldiv_if
// Handshake/data bundle between the decode stage and the mul/div sequencer.
//   start  : one-cycle issue pulse from decode
//   op     : operation code (MULT, MULTU, DIV, DIVU, MTHI, MTLO, reserved)
//   a, b   : rs / rt operands
//   cancel : pipeline flush, aborts an in-flight operation
//   hi, lo : architectural HI/LO registers
//   busy   : operation in flight (stall source)
//   done   : one-cycle pulse when HI/LO commit
//   dbz    : qualifies done, the divide had a zero divisor
// The master modport is the decode/CPU side, the slave modport is the sequencer.
interface muldiv_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        dbz;

    modport master (
        output start, op, a, b, cancel,
        input  hi, lo, busy, done, dbz
    );

    modport slave (
        input  start, op, a, b, cancel,
        output hi, lo, busy, done, dbz
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Multi-cycle sequencer around an unregistered multiplier and divider. It owns
// the architectural HI/LO registers and stalls the CPU while a MULT/MULTU/DIV/
// DIVU result settles through the combinational array (a multicycle path of
// MUL_CYCLES or DIV_CYCLES cycles). MTHI/MTLO write HI/LO in a single edge.
// Ports:
//   clk : single clock, all state changes on the rising edge
//   rst : synchronous active-high reset, clears HI/LO and aborts any operation
//   bus : muldiv_if.slave (start/op/a/b/cancel in, hi/lo/busy/done/dbz out)
// Parameters:
//   MUL_CYCLES : busy cycles for MULT/MULTU (1..15)
//   DIV_CYCLES : busy cycles for DIV/DIVU  (1..15)
module muldiv_sequencer #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_t;

    localparam logic KIND_MUL = 1'b0;
    localparam logic KIND_DIV = 1'b1;

    // The counter is loaded with N-1 so that busy spans exactly N cycles:
    // the load edge plus N-1 decrement edges, the commit happening on the
    // edge where the counter is already zero.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    // Sequencer state and operand registers
    state_t      state,  state_n;
    logic [3:0]  cnt,    cnt_n;
    logic [31:0] opa,    opa_n;
    logic [31:0] opb,    opb_n;
    logic        sign,   sign_n;
    logic        kind,   kind_n;

    // Architectural and status registers driven onto the bus
    logic [31:0] hi_q,   hi_n;
    logic [31:0] lo_q,   lo_n;
    logic        busy_q, busy_n;
    logic        done_q, done_n;
    logic        dbz_q,  dbz_n;

    // Datapath nets
    logic [63:0] product;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] safe_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;
    logic [63:0] ext_a;
    logic [63:0] ext_b;

    // Multiplier: sign-extending both operands to 64 bits when sign is set
    // makes the low 64 bits of an unsigned 64x64 product equal to the signed
    // 32x32 product, so one array serves MULT and MULTU.
    always_comb begin
        ext_a   = {{32{sign & opa[31]}}, opa};
        ext_b   = {{32{sign & opb[31]}}, opb};
        product = ext_a * ext_b;
    end

    // Divider: work on magnitudes and restore signs afterwards. The quotient
    // is negative when exactly one operand is negative (truncation toward
    // zero); the remainder follows the dividend. For 0x80000000 / -1 the
    // magnitude quotient is 0x80000000 and negating it wraps back to itself,
    // which is the architected result. A zero divisor is replaced by one so
    // the array never sees a divide by zero; its result is discarded anyway.
    always_comb begin
        neg_a     = sign & opa[31];
        neg_b     = sign & opb[31];
        mag_a     = neg_a ? (~opa + 32'd1) : opa;
        mag_b     = neg_b ? (~opb + 32'd1) : opb;
        div_zero  = (opb == 32'd0);
        safe_b    = div_zero ? 32'd1 : mag_b;
        mag_q     = mag_a / safe_b;
        mag_r     = mag_a % safe_b;
        quotient  = (neg_a ^ neg_b) ? (~mag_q + 32'd1) : mag_q;
        remainder = neg_a ? (~mag_r + 32'd1) : mag_r;
    end

    // State register. Reset is synchronous and wins over everything,
    // including an in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            opa    <= 32'd0;
            opb    <= 32'd0;
            sign   <= 1'b0;
            kind   <= KIND_MUL;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            opa    <= opa_n;
            opb    <= opb_n;
            sign   <= sign_n;
            kind   <= kind_n;
            hi_q   <= hi_n;
            lo_q   <= lo_n;
            busy_q <= busy_n;
            done_q <= done_n;
            dbz_q  <= dbz_n;
        end
    end

    // Next-state and register update logic.
    // In IDLE a start (not masked by a same-cycle cancel) either launches a
    // multi-cycle op, latching operands so the array inputs stay stable for
    // the whole wait, or performs an MTHI/MTLO write directly. In a WAIT
    // state start is ignored; cancel aborts without touching HI/LO, and
    // because it is tested before the commit it also wins on the commit edge.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        opa_n   = opa;
        opb_n   = opb;
        sign_n  = sign;
        kind_n  = kind;
        hi_n    = hi_q;
        lo_n    = lo_q;
        done_n  = 1'b0;
        dbz_n   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            opa_n   = bus.a;
                            opb_n   = bus.b;
                            sign_n  = (bus.op == OP_MULT);
                            kind_n  = KIND_MUL;
                            cnt_n   = MUL_LOAD;
                            state_n = MUL_WAIT;
                        end
                        OP_DIV, OP_DIVU: begin
                            opa_n   = bus.a;
                            opb_n   = bus.b;
                            sign_n  = (bus.op == OP_DIV);
                            kind_n  = KIND_DIV;
                            cnt_n   = DIV_LOAD;
                            state_n = DIV_WAIT;
                        end
                        OP_MTHI: hi_n = bus.a;
                        OP_MTLO: lo_n = bus.a;
                        default: ;
                    endcase
                end
            end

            MUL_WAIT, DIV_WAIT: begin
                if (bus.cancel) begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end else if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    if (kind == KIND_MUL) begin
                        hi_n = product[63:32];
                        lo_n = product[31:0];
                    end else if (div_zero) begin
                        dbz_n = 1'b1;
                    end else begin
                        hi_n = remainder;
                        lo_n = quotient;
                    end
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = 4'd0;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dbz  = dbz_q;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the CPU's combinational multiplier and divider. It holds the architectural HI/LO registers and is the stall source for MULT/MULTU/DIV/DIVU/MTHI/MTLO. The decode stage issues an operation with a one-cycle `start` pulse. The block latches the operands, lets the unregistered MUL/DIV array settle for a fixed number of cycles (declared as a multicycle path), then commits the result to HI/LO.

## Interface
Parameters:
- `MUL_CYCLES`, default 2: cycles `busy` stays high for MULT/MULTU. Legal range 1–15.
- `DIV_CYCLES`, default 8: cycles `busy` stays high for DIV/DIVU. Legal range 1–15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  issue pulse, sampled on the rising edge.
- `op`  in  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (treated as no-op).
- `a`  in  32  rs operand (dividend / multiplicand / MTxx source).
- `b`  in  32  rt operand (divisor / multiplier).
- `cancel`  in  1  pipeline flush; aborts an in-flight operation.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `busy`  out  1  operation in flight; the CPU stalls MFHI/MFLO and further mul/div ops while this is high.
- `done`  out  1  one-cycle pulse when HI/LO commit.
- `dbz`  out  1  qualifies `done`: the divide had divisor 0.

## Operation
- Registers: `opa`, `opb`, `sign`, `kind` (mul/div), a 4-bit down-counter `cnt`, and `state` ∈ {IDLE, MUL_WAIT, DIV_WAIT}.
- Datapath: one multiplier (64-bit product) and one divider (quotient, remainder, divide-by-zero flag) are instantiated internally.
  - Both are fed only from `opa`/`opb`/`sign`, never directly from `a`/`b`.
  - Signed ops set `sign=1`; unsigned ops set `sign=0`.
- IDLE, on `start` with MULT/MULTU:
  - Latch the operands and sign.
  - Load `cnt = MUL_CYCLES-1`; go to MUL_WAIT.
- IDLE, on `start` with DIV/DIVU: same, with `cnt = DIV_CYCLES-1`; go to DIV_WAIT.
- IDLE, on `start` with MTHI or MTLO: write `a` into `hi` or `lo` on the same edge. No busy, no `done`, stay in IDLE.
- IDLE, on `start` with a reserved op: no effect.
- WAIT states:
  - `cnt != 0`: decrement.
  - `cnt == 0`: commit and return to IDLE.
- MUL commit: `hi` = product[63:32], `lo` = product[31:0].
- DIV commit with divisor ≠ 0: `lo` = quotient, `hi` = remainder.
  - The remainder takes the dividend's sign; the quotient truncates toward zero.
- DIV commit with divisor = 0: `hi`/`lo` unchanged; `dbz` pulses with `done`.
- 0x80000000 / −1 signed: `lo` = 0x80000000, `hi` = 0. No trap.
- `start` while `busy=1` is ignored: no latch, no effect on the in-flight op. The CPU must never do this; the bench checks that it is ignored.
- `cancel` in a WAIT state:
  - Return to IDLE next edge; `hi`/`lo` unchanged; no `done`.
  - If `cancel` coincides with the commit edge, the cancel wins.
- `cancel` in IDLE: no effect, and it also suppresses a same-cycle `start` (MTHI/MTLO included).
- `rst` overrides everything. Mid-operation it aborts to IDLE and clears HI/LO.

## Timing
- Reset values: `hi=0`, `lo=0`, `busy=0`, `done=0`, `dbz=0`, `state=IDLE`, `cnt=0`.
- `start` sampled at edge E0 → `busy=1` from E0 through E_N, where N = MUL_CYCLES or DIV_CYCLES. The op therefore stalls the CPU for exactly N cycles.
- At edge E_N: `hi`/`lo` take new values, `busy` falls, `done` (and `dbz` if applicable) are high for the single cycle after E_N.
- Back-to-back: a new `start` is accepted in the cycle `done` is high (state is IDLE then). A MULT/MULTU/DIV/DIVU has a throughput of N+1 cycles; an MTxx accepted in that slot writes on that edge.
- MTHI/MTLO latency: 1 edge, with the new value visible the cycle after `start`.
- `busy`, `done`, `dbz`, `hi`, `lo` are all registered outputs; none depend combinationally on inputs.
- The multiplier/divider outputs to `hi`/`lo` are a multicycle path of N cycles; operand registers change only in IDLE.

## Test plan
- Reset, then MULT a=0xFFFFFFFD (−3), b=5, with the default MUL_CYCLES=2 → `busy` high for 2 cycles; `done` pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 → `busy` high for exactly 8 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU same operands → lo=0x7FFFFFFC, hi=0x00000001.
- DIVU a=7, b=0, with hi=0x11, lo=0x22 preloaded via MTHI/MTLO (each visible 1 cycle later, no busy) → `done` and `dbz` pulse together; hi=0x11 and lo=0x22 unchanged.
- MULT in flight; second `start` (DIV) in cycle 1 → ignored; commit at the MUL edge with the MUL result. Then a new DIV issued in the `done` cycle → accepted, `busy` re-rises next cycle.
- DIV in flight; `cancel` at cycle 4 → IDLE, no `done`, HI/LO unchanged. Repeat with `cancel` on the commit cycle → no commit. Repeat with `rst` at cycle 4 → all outputs 0.
- Signed 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, dbz=0.
